// File: rtl/snake_grid_map_pkg.sv
// Shared grid geometry, direction and map-FSM encodings for the snake game blocks.
// Also provides range checks for grid coordinates.
package snake_grid_map_pkg;

    localparam int unsigned H_LOGIC_WIDTH = 5;
    localparam int unsigned V_LOGIC_WIDTH = 5;
    localparam logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX = 5'd31;
    localparam logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX = 5'd23;
    localparam int unsigned LEN_WIDTH = 10;

    localparam int unsigned ROW_BITS = int'(H_LOGIC_MAX) + 1;
    localparam int unsigned NUM_ROWS = int'(V_LOGIC_MAX) + 1;

    typedef enum logic [1:0] {
        DirUp,
        DirDown,
        DirLeft,
        DirRight
    } dir_e;

    typedef enum logic [2:0] {
        StInit,
        StReady,
        StChk,
        StSet,
        StClr
    } map_state_e;

    // Borrow-based range checks: valid when MAX - coord does not underflow.
    function automatic logic col_ok(logic [H_LOGIC_WIDTH-1:0] x);
        logic [H_LOGIC_WIDTH:0] diff;
        diff = {1'b0, H_LOGIC_MAX} - {1'b0, x};
        return !diff[H_LOGIC_WIDTH];
    endfunction

    function automatic logic row_ok(logic [V_LOGIC_WIDTH-1:0] y);
        logic [V_LOGIC_WIDTH:0] diff;
        diff = {1'b0, V_LOGIC_MAX} - {1'b0, y};
        return !diff[V_LOGIC_WIDTH];
    endfunction

endpackage

// File: rtl/snake_row_ram.sv
// Snake occupancy map: one bit per grid cell, one word per row.
// Provides a registered query read, a combinational update read, a bit write and a row clear.
module snake_row_ram
    import snake_grid_map_pkg::*;
(
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic [V_LOGIC_WIDTH-1:0] rd_row,
    output logic [ROW_BITS-1:0]      rd_data,
    input  logic [V_LOGIC_WIDTH-1:0] upd_row,
    output logic [ROW_BITS-1:0]      upd_data,
    input  logic                     wr_en,
    input  logic [V_LOGIC_WIDTH-1:0] wr_row,
    input  logic [H_LOGIC_WIDTH-1:0] wr_col,
    input  logic                     wr_val,
    input  logic                     clr_en,
    input  logic [V_LOGIC_WIDTH-1:0] clr_row
);

    logic [ROW_BITS-1:0] mem_q [NUM_ROWS];
    logic [ROW_BITS-1:0] rd_data_q;

    // Read samples the word before any write landing on the same edge.
    always_ff @(posedge clk) begin
        if (rd_en && row_ok(rd_row)) begin
            rd_data_q <= mem_q[rd_row];
        end
        if (clr_en && row_ok(clr_row)) begin
            mem_q[clr_row] <= '0;
        end else if (wr_en && row_ok(wr_row)) begin
            mem_q[wr_row][wr_col] <= wr_val;
        end
    end

    assign rd_data = rd_data_q;

    always_comb begin
        upd_data = '0;
        if (row_ok(upd_row)) begin
            upd_data = mem_q[upd_row];
        end
    end

endmodule

// File: rtl/snake_grid_map.sv
// Tracks snake-occupied grid cells from the move stream, flags self-collision,
// and answers per-cell snake/prey queries with one cycle of latency.
module snake_grid_map
    import snake_grid_map_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upd_vld,
    output logic                     upd_rdy,
    input  logic [H_LOGIC_WIDTH-1:0] upd_headx,
    input  logic [V_LOGIC_WIDTH-1:0] upd_heady,
    input  logic [H_LOGIC_WIDTH-1:0] upd_tailx,
    input  logic [V_LOGIC_WIDTH-1:0] upd_taily,
    input  logic                     upd_score,
    input  logic [H_LOGIC_WIDTH-1:0] preyx,
    input  logic [V_LOGIC_WIDTH-1:0] preyy,
    input  logic                     q_req,
    input  logic [H_LOGIC_WIDTH-1:0] q_x,
    input  logic [V_LOGIC_WIDTH-1:0] q_y,
    output logic                     q_vld,
    output logic                     q_snake,
    output logic                     q_prey,
    output logic                     collide,
    output logic                     upd_drop,
    output logic [LEN_WIDTH-1:0]     snake_len
);

    map_state_e state_q, state_d;
    logic [V_LOGIC_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic [H_LOGIC_WIDTH-1:0] head_x_q, head_x_d, tail_x_q, tail_x_d;
    logic [V_LOGIC_WIDTH-1:0] head_y_q, head_y_d, tail_y_q, tail_y_d;
    logic score_q, score_d;
    logic collide_q, collide_d, drop_q, drop_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic q_vld_q, q_vld_d, q_prey_q, q_prey_d, q_oob_q, q_oob_d;
    logic [H_LOGIC_WIDTH-1:0] q_x_q, q_x_d;

    logic [ROW_BITS-1:0] q_word, upd_word;
    logic [V_LOGIC_WIDTH-1:0] upd_row, wr_row;
    logic [H_LOGIC_WIDTH-1:0] wr_col;
    logic wr_en, wr_val, clr_en;
    logic head_ok, tail_ok, same_cell, head_bit, tail_bit, tail_clr;

    snake_row_ram u_ram (
        .clk      (clk),
        .rd_en    (q_req),
        .rd_row   (q_y),
        .rd_data  (q_word),
        .upd_row  (upd_row),
        .upd_data (upd_word),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_val   (wr_val),
        .clr_en   (clr_en),
        .clr_row  (row_cnt_q)
    );

    always_comb begin
        head_ok   = col_ok(head_x_q) && row_ok(head_y_q);
        tail_ok   = col_ok(tail_x_q) && row_ok(tail_y_q);
        same_cell = ({head_x_q, head_y_q} == {tail_x_q, tail_y_q});
        upd_row   = (state_q == StClr) ? tail_y_q : head_y_q;
        head_bit  = upd_word[head_x_q];
        tail_bit  = upd_word[tail_x_q];
        tail_clr  = !score_q && !same_cell && tail_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (row_cnt_q == V_LOGIC_MAX) state_d = StReady;
            StReady: if (upd_vld) state_d = StChk;
            StChk:   state_d = StSet;
            StSet:   state_d = StClr;
            StClr:   state_d = StReady;
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        upd_rdy = 1'b0;
        clr_en  = 1'b0;
        wr_en   = 1'b0;
        wr_row  = head_y_q;
        wr_col  = head_x_q;
        wr_val  = 1'b1;
        unique case (state_q)
            StInit:  clr_en = 1'b1;
            StReady: upd_rdy = 1'b1;
            StSet:   wr_en = head_ok;
            StClr: begin
                wr_en  = tail_clr;
                wr_row = tail_y_q;
                wr_col = tail_x_q;
                wr_val = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        row_cnt_d = (state_q == StInit) ? row_cnt_q + 1'b1 : row_cnt_q;
        head_x_d  = head_x_q;
        head_y_d  = head_y_q;
        tail_x_d  = tail_x_q;
        tail_y_d  = tail_y_q;
        score_d   = score_q;
        if (state_q == StReady && upd_vld) begin
            head_x_d = upd_headx;
            head_y_d = upd_heady;
            tail_x_d = upd_tailx;
            tail_y_d = upd_taily;
            score_d  = upd_score;
        end
        collide_d = collide_q;
        if (state_q == StChk && head_ok && head_bit && !(same_cell && !score_q)) begin
            collide_d = 1'b1;
        end
        drop_d = drop_q | (upd_vld & ~upd_rdy);
        len_d  = len_q;
        if (state_q == StSet && head_ok && !head_bit && len_q != {LEN_WIDTH{1'b1}}) begin
            len_d = len_q + 1'b1;
        end else if (state_q == StClr && tail_clr && tail_bit && len_q != '0) begin
            len_d = len_q - 1'b1;
        end
        q_vld_d  = q_req;
        q_x_d    = q_req ? q_x : q_x_q;
        q_oob_d  = q_req ? !(col_ok(q_x) && row_ok(q_y)) : q_oob_q;
        q_prey_d = q_req ? ({q_x, q_y} == {preyx, preyy}) : q_prey_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt_q <= '0;
            head_x_q  <= '0;
            head_y_q  <= '0;
            tail_x_q  <= '0;
            tail_y_q  <= '0;
            score_q   <= 1'b0;
            collide_q <= 1'b0;
            drop_q    <= 1'b0;
            len_q     <= '0;
            q_vld_q   <= 1'b0;
            q_x_q     <= '0;
            q_oob_q   <= 1'b1;
            q_prey_q  <= 1'b0;
        end else begin
            row_cnt_q <= row_cnt_d;
            head_x_q  <= head_x_d;
            head_y_q  <= head_y_d;
            tail_x_q  <= tail_x_d;
            tail_y_q  <= tail_y_d;
            score_q   <= score_d;
            collide_q <= collide_d;
            drop_q    <= drop_d;
            len_q     <= len_d;
            q_vld_q   <= q_vld_d;
            q_x_q     <= q_x_d;
            q_oob_q   <= q_oob_d;
            q_prey_q  <= q_prey_d;
        end
    end

    // Out-of-range query cells read as empty.
    assign q_snake   = !q_oob_q && q_word[q_x_q];
    assign q_vld     = q_vld_q;
    assign q_prey    = q_prey_q;
    assign collide   = collide_q;
    assign upd_drop  = drop_q;
    assign snake_len = len_q;

endmodule
